// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU data-memory initiator.
// Op size codes, FSM states and watchdog sizing.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int OP_ZEXT = 2;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_t;

    function automatic logic misaligned(input logic [2:0] op,
                                        input logic [1:0] a);
        logic res;
        res = 1'b0;
        unique case (op[1:0])
            SZ_B:    res = 1'b0;
            SZ_H:    res = a[0];
            default: res = |a;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store mask and replicated write data,
// load lane extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        wen,
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [15:0] lane;
    logic [3:0]  mask;
    logic        sx;

    always_comb begin
        lane       = 16'(rdata >> {addr_lo, 3'b000});
        sx         = ~op[OP_ZEXT];
        mask       = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata;
        // Shifts stay 4 bits wide, so lanes past byte 3 fall off.
        unique case (op[1:0])
            SZ_B: begin
                mask       = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{sx & lane[7]}}, lane[7:0]};
            end
            SZ_H: begin
                mask       = 4'b0011 << addr_lo;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{sx & lane[15]}}, lane};
            end
            default: begin
            end
        endcase
        wmask = wen ? mask : 4'b0000;
    end

endmodule

// File: rtl/lsu_mem_master.sv
// LSU initiator: one outstanding PMEM access with watchdog.
// Optional LSU_MISALIGN_CHECK_EN rejects misaligned H/W accesses.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wen,
    input  logic [2:0]        in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rdata,
    output logic              out_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [7:0]        mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state, state_n;
    logic                wen_q;
    logic [2:0]          op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

    logic                ld;
    logic                done_set;
    logic                done_err;
    logic [DATA_W-1:0]   done_data;
    logic                tmo_hit;
    logic [3:0]          lane_mask;
    logic [DATA_W-1:0]   lane_wdata;
    logic [DATA_W-1:0]   rdata_ext;

    lsu_align u_align (
        .wen        (wen_q),
        .op         (op_q),
        .addr_lo    (addr_q[1:0]),
        .wdata      (wdata_q),
        .rdata      (mem_resp_rdata),
        .wmask      (lane_mask),
        .wdata_lane (lane_wdata),
        .rdata_ext  (rdata_ext)
    );

    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_n   = state;
        ld        = 1'b0;
        done_set  = 1'b0;
        done_err  = 1'b0;
        done_data = '0;
        unique case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    ld      = 1'b1;
                    state_n = ST_REQ;
`ifdef LSU_MISALIGN_CHECK_EN
                    if (misaligned(in_op, in_addr[1:0])) begin
                        state_n  = ST_DONE;
                        done_set = 1'b1;
                        done_err = 1'b1;
                    end
`endif
                end
            end
            ST_REQ: begin
                if (mem_req_ready)
                    state_n = ST_WAIT;
            end
            ST_WAIT: begin
                // A response in the expiry cycle still wins.
                if (mem_resp_valid) begin
                    state_n   = ST_DONE;
                    done_set  = 1'b1;
                    done_data = wen_q ? '0 : rdata_ext;
                end else if (tmo_hit) begin
                    state_n  = ST_DONE;
                    done_set = 1'b1;
                    done_err = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready)
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            wen_q   <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_n;
            if (ld) begin
                wen_q   <= in_wen;
                op_q    <= in_op;
                addr_q  <= in_addr;
                wdata_q <= in_wdata;
            end
            cnt_q <= (state == ST_WAIT) ? cnt_q + 1'b1 : '0;
            if (done_set) begin
                rdata_q <= done_data;
                err_q   <= done_err;
            end
        end
    end

    assign in_ready      = (state == ST_IDLE);
    assign out_valid     = (state == ST_DONE);
    assign out_rdata     = rdata_q;
    assign out_err       = err_q;
    assign mem_req_valid = (state == ST_REQ);
    assign mem_req_wen   = wen_q;
    assign mem_req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_req_wdata = lane_wdata;
    assign mem_req_wmask = {4'b0000, lane_mask};

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: directed loads/stores,
// stalls, watchdog expiry, stray response and mid-access reset.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_wen;
    logic [2:0]  in_op;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic        out_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;

    always #5 clk = ~clk;

    lsu_mem_master #(.TIMEOUT(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_wen         (in_wen),
        .in_op          (in_op),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_rdata      (out_rdata),
        .out_err        (out_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_wen    (mem_req_wen),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata)
    );

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  wmask;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // stimulus-owned knobs
    int          rdy_delay = 0;
    int          out_delay = 0;
    logic [31:0] mem_word  = '0;
    bit          resp_en   = 1'b1;
    int          stray_req = 0;
    int          tmo_req   = 0;

    // monitor-owned state
    int rq_rd   = 0;
    int rsp_rd  = 0;
    int hs_cnt  = 0;
    int tmo_ack = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory and WBU responder.
    initial begin : responder
        int hs_last = 0;
        int stray_ack = 0;
        int wcnt = 0;
        int ocnt = 0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        out_ready      = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mem_resp_valid = 1'b0;
            if (hs_cnt != hs_last) begin
                hs_last = hs_cnt;
                if (resp_en) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = mem_word;
                end
            end else if (stray_req != stray_ack) begin
                stray_ack      = stray_req;
                mem_resp_valid = 1'b1;
                mem_resp_rdata = 32'hDEAD_BEEF;
            end
            if (mem_req_valid) begin
                if (wcnt >= rdy_delay) mem_req_ready = 1'b1;
                else begin
                    mem_req_ready = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_req_ready = 1'b0;
                wcnt = 0;
            end
            if (out_valid) begin
                if (ocnt >= out_delay) out_ready = 1'b1;
                else begin
                    out_ready = 1'b0;
                    ocnt++;
                end
            end else begin
                out_ready = 1'b0;
                ocnt = 0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin : monitor
        bit busy = 1'b0;
        bit prev_rst = 1'b1;
        bit ov_seen = 1'b0;
        int acc_cyc = 0;
        int ov_cyc = 0;
        forever begin
            @(negedge clk);
            if (tmo_req != tmo_ack) begin
                tmo_ack = tmo_req;
                total++;
                bad++;
                $display("FAIL wait_bound got=expired want=done (cycle %0d)", cyc);
            end
            if (rst) begin
                busy    = 1'b0;
                ov_seen = 1'b0;
            end else begin
                if (prev_rst) begin
                    chk("rst_in_ready", 32'(in_ready), 32'd1);
                    chk("rst_out_valid", 32'(out_valid), 32'd0);
                    chk("rst_out_rdata", out_rdata, 32'd0);
                    chk("rst_out_err", 32'(out_err), 32'd0);
                    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
                    chk("rst_req_wen", 32'(mem_req_wen), 32'd0);
                    chk("rst_req_addr", mem_req_addr, 32'd0);
                    chk("rst_req_wdata", mem_req_wdata, 32'd0);
                    chk("rst_req_wmask", 32'(mem_req_wmask), 32'd0);
                end
                chk("in_ready_busy", 32'(in_ready), 32'(!busy));
                if (in_valid && in_ready) begin
                    busy    = 1'b1;
                    acc_cyc = cyc;
                end
                if (mem_req_valid) begin
                    if (rq_rd < req_q.size()) begin
                        chk("req_wen", 32'(mem_req_wen), 32'(req_q[rq_rd].wen));
                        chk("req_addr", mem_req_addr, req_q[rq_rd].addr);
                        chk("req_wmask", 32'(mem_req_wmask), 32'(req_q[rq_rd].wmask));
                        if (req_q[rq_rd].wen)
                            chk("req_wdata", mem_req_wdata, req_q[rq_rd].wdata);
                        if (mem_req_ready) begin
                            rq_rd++;
                            hs_cnt++;
                        end
                    end else begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_req got=addr %h want=none", mem_req_addr);
                        if (mem_req_ready) hs_cnt++;
                    end
                end
                if (out_valid) begin
                    if (!ov_seen) begin
                        ov_seen = 1'b1;
                        ov_cyc  = cyc;
                    end
                    if (rsp_rd < rsp_q.size()) begin
                        chk("out_rdata", out_rdata, rsp_q[rsp_rd].rdata);
                        chk("out_err", 32'(out_err), 32'(rsp_q[rsp_rd].err));
                        if (out_ready) begin
                            if (rsp_q[rsp_rd].lat >= 0)
                                chk("latency", 32'(ov_cyc - acc_cyc),
                                    32'(rsp_q[rsp_rd].lat));
                            rsp_rd++;
                            busy    = 1'b0;
                            ov_seen = 1'b0;
                        end
                    end else begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out got=%h want=none", out_rdata);
                    end
                end
            end
            prev_rst = rst;
        end
    end

    task automatic issue(input logic wen, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] mw, input int rd, input int od,
                         input bit ren, input bit has_req,
                         input logic [31:0] e_addr, input logic [31:0] e_wd,
                         input logic [7:0] e_m, input logic [31:0] e_rd,
                         input logic e_err, input int lat, input bit wait_done);
        int n;
        rdy_delay = rd;
        out_delay = od;
        mem_word  = mw;
        resp_en   = ren;
        if (has_req) req_q.push_back('{wen, e_addr, e_wd, e_m});
        if (wait_done) rsp_q.push_back('{e_rd, e_err, lat});
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) tmo_req++;
        in_wen   = wen;
        in_op    = op;
        in_addr  = addr;
        in_wdata = wd;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (wait_done) begin
            n = 0;
            while (rsp_rd < rsp_q.size() && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (n >= 100) tmo_req++;
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1);
    end

    initial begin : stim
        rst      = 1'b1;
        in_valid = 1'b0;
        in_wen   = 1'b0;
        in_op    = '0;
        in_addr  = '0;
        in_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // SB lane 3
        issue(1, 3'b000, 32'h8000_0003, 32'h0000_00AB, 32'h1122_3344, 0, 0, 1, 1,
              32'h8000_0000, 32'hABAB_ABAB, 8'h08, 32'h0, 0, 3, 1);
        // LB / LBU lane 1
        issue(0, 3'b000, 32'h8000_0001, 32'h0, 32'h1234_80FF, 0, 0, 1, 1,
              32'h8000_0000, 32'h0, 8'h00, 32'hFFFF_FF80, 0, 3, 1);
        issue(0, 3'b100, 32'h8000_0001, 32'h0, 32'h1234_80FF, 0, 0, 1, 1,
              32'h8000_0000, 32'h0, 8'h00, 32'h0000_0080, 0, 3, 1);
        // LH upper half, zero-wait latency
        issue(0, 3'b001, 32'h8000_0002, 32'h0, 32'h8001_0000, 0, 0, 1, 1,
              32'h8000_0000, 32'h0, 8'h00, 32'hFFFF_8001, 0, 3, 1);
        // SW with request and result back-pressure
        issue(1, 3'b010, 32'h8000_0010, 32'hCAFE_F00D, 32'h0, 5, 3, 1, 1,
              32'h8000_0010, 32'hCAFE_F00D, 8'h0F, 32'h0, 0, 8, 1);
        // SH lane 2, LW, illegal size as word
        issue(1, 3'b001, 32'h8000_0006, 32'h0000_5A5A, 32'h0, 0, 0, 1, 1,
              32'h8000_0004, 32'h5A5A_5A5A, 8'h0C, 32'h0, 0, 3, 1);
        issue(0, 3'b010, 32'h8000_0004, 32'h0, 32'h89AB_CDEF, 0, 0, 1, 1,
              32'h8000_0004, 32'h0, 8'h00, 32'h89AB_CDEF, 0, 3, 1);
        issue(0, 3'b011, 32'h8000_000C, 32'h0, 32'h0102_0304, 0, 0, 1, 1,
              32'h8000_000C, 32'h0, 8'h00, 32'h0102_0304, 0, 3, 1);
        issue(1, 3'b011, 32'h8000_000C, 32'h7654_3210, 32'h0, 0, 0, 1, 1,
              32'h8000_000C, 32'h7654_3210, 8'h0F, 32'h0, 0, 3, 1);
        // watchdog expiry, then a stray response that must be dropped
        issue(0, 3'b010, 32'h8000_0020, 32'h0, 32'h5555_5555, 0, 0, 0, 1,
              32'h8000_0020, 32'h0, 8'h00, 32'h0, 1, 10, 1);
        stray_req++;
        repeat (4) @(posedge clk);
        #1;
        issue(0, 3'b101, 32'h8000_0006, 32'h0, 32'hBEEF_1234, 0, 0, 1, 1,
              32'h8000_0004, 32'h0, 8'h00, 32'h0000_BEEF, 0, 3, 1);
`ifdef LSU_MISALIGN_CHECK_EN
        issue(0, 3'b010, 32'h8000_0002, 32'h0, 32'h0, 0, 0, 1, 0,
              32'h0, 32'h0, 8'h00, 32'h0, 1, 1, 1);
        issue(1, 3'b001, 32'h8000_0003, 32'h1234, 32'h0, 0, 0, 1, 0,
              32'h0, 32'h0, 8'h00, 32'h0, 1, 1, 1);
`else
        issue(1, 3'b001, 32'h8000_0003, 32'h0000_1234, 32'h0, 0, 0, 1, 1,
              32'h8000_0000, 32'h1234_1234, 8'h08, 32'h0, 0, 3, 1);
`endif
        // reset while waiting for a response
        issue(0, 3'b010, 32'h8000_0040, 32'h0, 32'h0, 0, 0, 0, 1,
              32'h8000_0040, 32'h0, 8'h00, 32'h0, 0, -1, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        issue(0, 3'b000, 32'h8000_0000, 32'h0, 32'h0000_007F, 0, 0, 1, 1,
              32'h8000_0000, 32'h0, 8'h00, 32'h0000_007F, 0, 3, 1);
        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
